// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock dividers: board clock rate and
// the half-period counts for the standard refresh, debounce and step rates.
package clk_div_pkg;

  localparam int unsigned SYS_CLK_HZ    = 100_000_000;
  localparam int          DEFAULT_CNT_W = 32;

  function automatic int unsigned half_count(input int unsigned freq_hz);
    return SYS_CLK_HZ / freq_hz / 2;
  endfunction

  localparam int unsigned HALF_480HZ = half_count(480);
  localparam int unsigned HALF_1KHZ  = half_count(1000);
  localparam int unsigned HALF_1HZ   = half_count(1);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter with a shadowed half-period value
// that only takes effect at the end of a full period, or at once while idle.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = DEFAULT_CNT_W,
  parameter int unsigned DEFAULT_HALF = HALF_480HZ
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             resync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] wr_clamped;
  logic             idle;
  logic             toggle;
  logic             boundary;

  always_comb begin
    wr_clamped = (wr_half == '0) ? CNT_W'(1) : wr_half;
    idle       = !en || resync;
    toggle     = (cnt_q == active_q - CNT_W'(1));
    // A period ends on the high-to-low toggle; idling also counts as a boundary.
    boundary   = idle || (toggle && clk_q);

    cnt_d     = cnt_q + CNT_W'(1);
    clk_d     = clk_q;
    tick_d    = 1'b0;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (idle) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (toggle) begin
      cnt_d  = '0;
      clk_d  = !clk_q;
      tick_d = !clk_q;
    end

    if (boundary) begin
      if (wr) begin
        active_d  = wr_clamped;
        shadow_d  = wr_clamped;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (wr) begin
      shadow_d  = wr_clamped;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      active_q  <= RESET_HALF;
      shadow_q  <= RESET_HALF;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: decodes the half-period write
// port and fans out to NUM_CH independent divider channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int          NUM_CH       = 4,
  parameter  int          CNT_W        = DEFAULT_CNT_W,
  parameter  int unsigned DEFAULT_HALF = HALF_480HZ,
  localparam int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              resync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  // Channel indices at or above NUM_CH match no instance, so such writes vanish.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic wr_sel;
    assign wr_sel = wr_en && (wr_ch == CH_W'(gi));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_chan (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .en     (en[gi]),
      .resync (resync),
      .wr     (wr_sel),
      .wr_half(wr_half),
      .clk_out(clk_out[gi]),
      .tick   (tick[gi]),
      .pending(pending[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a 4-channel and a 3-channel instance share stimulus
// and are checked every cycle against a period-position model.
module tb_clk_div_multi;

  localparam int NA = 4;
  localparam int NB = 3;
  localparam int NT = NA + NB;
  localparam int DEF_HALF = 3;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [3:0]    en;
  logic          resync;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [31:0]   wr_half;
  logic [NA-1:0] clk_a, tick_a, pend_a;
  logic [NB-1:0] clk_b, tick_b, pend_b;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  clk_div_multi #(.NUM_CH(NA), .CNT_W(32), .DEFAULT_HALF(DEF_HALF)) u_dut_a (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .en     (en),
    .resync (resync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_half(wr_half),
    .clk_out(clk_a),
    .tick   (tick_a),
    .pending(pend_a)
  );

  clk_div_multi #(.NUM_CH(NB), .CNT_W(32), .DEFAULT_HALF(DEF_HALF)) u_dut_b (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .en     (en[NB-1:0]),
    .resync (resync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_half(wr_half),
    .clk_out(clk_b),
    .tick   (tick_b),
    .pending(pend_b)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: position within the current period; output high for the second half.
  int m_pos[NT];
  int m_act[NT];
  int m_shd[NT];
  bit m_pend[NT];

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NT; c++) begin
        m_pos[c]  = 0;
        m_act[c]  = DEF_HALF;
        m_shd[c]  = DEF_HALF;
        m_pend[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NT; c++) begin
        int k, h;
        bit e, w, idle, period_end;
        k = (c < NA) ? c : c - NA;
        e = en[k];
        w = wr_en && (int'(wr_ch) == k);
        h = (wr_half == 0) ? 1 : int'(wr_half);
        idle = !e || resync;
        period_end = !idle && (m_pos[c] + 1 == 2 * m_act[c]);
        if (idle || period_end) begin
          m_pos[c] = 0;
          if (w) begin
            m_act[c]  = h;
            m_shd[c]  = h;
            m_pend[c] = 1'b0;
          end else if (m_pend[c]) begin
            m_act[c]  = m_shd[c];
            m_pend[c] = 1'b0;
          end
        end else begin
          m_pos[c] = m_pos[c] + 1;
          if (w) begin
            m_shd[c]  = h;
            m_pend[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    logic [NA-1:0] ec_a, et_a, ep_a;
    logic [NB-1:0] ec_b, et_b, ep_b;
    for (int c = 0; c < NT; c++) begin
      if (c < NA) begin
        ec_a[c] = (m_pos[c] >= m_act[c]);
        et_a[c] = (m_pos[c] == m_act[c]);
        ep_a[c] = m_pend[c];
      end else begin
        ec_b[c-NA] = (m_pos[c] >= m_act[c]);
        et_b[c-NA] = (m_pos[c] == m_act[c]);
        ep_b[c-NA] = m_pend[c];
      end
    end
    chk("cyc_clk_a", 32'(clk_a), 32'(ec_a));
    chk("cyc_tick_a", 32'(tick_a), 32'(et_a));
    chk("cyc_pend_a", 32'(pend_a), 32'(ep_a));
    chk("cyc_clk_b", 32'(clk_b), 32'(ec_b));
    chk("cyc_tick_b", 32'(tick_b), 32'(et_b));
    chk("cyc_pend_b", 32'(pend_b), 32'(ep_b));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic do_write(input int ch, input int half);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_half = 32'(half);
    step(1);
    wr_en = 1'b0;
    $display("wr ch=%0d half=%0d t=%0t", ch, half, $time);
  endtask

  initial begin
    logic [11:0] pat1_c, pat1_t;
    logic [14:0] pat2_c, pat2_p;
    logic [6:0]  pat4_c;
    int          rise[NA];
    int          exp_rise[NA];
    int          guard;

    reset_n = 1'b0;
    en      = 4'b0001;
    resync  = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_half = '0;
    step(2);
    chk("rst_clk", 32'(clk_a), 32'h0);
    chk("rst_tick", 32'(tick_a), 32'h0);
    chk("rst_pend", 32'(pend_a), 32'h0);
    reset_n = 1'b1;

    // Default half-period 3: period 6, rising on the third enabled edge.
    pat1_c = 12'b001110001110;
    pat1_t = 12'b001000001000;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("t1_clk0", 32'(clk_a[0]), 32'(pat1_c[11-k]));
      chk("t1_tick0", 32'(tick_a[0]), 32'(pat1_t[11-k]));
      chk("t1_idle", 32'(clk_a[3:1]), 32'h0);
    end

    // Mid-period write of 5: current 3/3 period finishes, then 5/5.
    do_write(0, 5);
    chk("t2_pend_set", 32'(pend_a[0]), 32'h1);
    pat2_c = 15'b011100000111110;
    pat2_p = 15'b111100000000000;
    for (int k = 0; k < 15; k++) begin
      step(1);
      chk("t2_clk0", 32'(clk_a[0]), 32'(pat2_c[14-k]));
      chk("t2_pend0", 32'(pend_a[0]), 32'(pat2_p[14-k]));
    end

    // Half-period 0 clamps to 1 on a disabled channel, applied at once.
    do_write(1, 0);
    chk("t3_pend1", 32'(pend_a[1]), 32'h0);
    en = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("t3_clk1", 32'(clk_a[1]), 32'((k % 2) == 0));
      chk("t3_tick1", 32'(tick_a[1]), 32'((k % 2) == 0));
    end

    // Write landing exactly on the high-to-low toggle takes the bypass path.
    guard = 0;
    while (!(m_pos[0] + 1 == 2 * m_act[0]) && guard < 40) begin
      step(1);
      guard++;
    end
    chk("t4_wait", 32'(guard < 40), 32'h1);
    do_write(0, 2);
    pat4_c = 7'b0011001;
    chk("t4_clk0", 32'(clk_a[0]), 32'(pat4_c[6]));
    chk("t4_pend0", 32'(pend_a[0]), 32'h0);
    for (int k = 1; k < 7; k++) begin
      step(1);
      chk("t4_clk0", 32'(clk_a[0]), 32'(pat4_c[6-k]));
      chk("t4_pend0", 32'(pend_a[0]), 32'h0);
    end

    // Resync with mixed phases and a same-cycle write on channel 0.
    do_write(2, 4);
    do_write(3, 7);
    en = 4'b1111;
    step(5);
    do_write(2, 6);
    step(2);
    resync  = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 2'd0;
    wr_half = 32'd3;
    step(1);
    resync = 1'b0;
    wr_en  = 1'b0;
    chk("t5_clk", 32'(clk_a), 32'h0);
    chk("t5_tick", 32'(tick_a), 32'h0);
    chk("t5_pend", 32'(pend_a), 32'h0);
    chk("t5_clk_b", 32'(clk_b), 32'h0);
    chk("t5_pend_b", 32'(pend_b), 32'h0);
    exp_rise = '{3, 1, 6, 7};
    rise     = '{-1, -1, -1, -1};
    for (int k = 1; k <= 10; k++) begin
      step(1);
      for (int c = 0; c < NA; c++)
        if (rise[c] < 0 && clk_a[c]) rise[c] = k;
    end
    for (int c = 0; c < NA; c++)
      chk("t5_rise", 32'(rise[c]), 32'(exp_rise[c]));

    // Asynchronous reset mid-count clears outputs without waiting for an edge.
    reset_n = 1'b0;
    #1;
    chk("t6_clk", 32'(clk_a), 32'h0);
    chk("t6_tick", 32'(tick_a), 32'h0);
    chk("t6_pend", 32'(pend_a), 32'h0);
    chk("t6_clk_b", 32'(clk_b), 32'h0);
    step(1);
    reset_n = 1'b1;
    do_write(3, 9);
    chk("t6_pend_a", 32'(pend_a), 32'h8);
    chk("t6_pend_b", 32'(pend_b), 32'h0);
    chk("t6_clk_w", 32'(clk_a), 32'h0);
    step(2);
    chk("t6_def_a", 32'(clk_a), 32'hf);
    chk("t6_def_b", 32'(clk_b), 32'h7);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) en[b] = ($urandom_range(0, 7) != 0);
      resync  = ($urandom_range(0, 39) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_half = 32'($urandom_range(0, 6));
      step(1);
    end
    resync = 1'b0;
    wr_en  = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
